// File: rtl/uart_cmd_decoder_pkg.sv
// Shared opcode constants and FSM state encoding for the UART command decoder.
// Pure declarations: no logic, no latency, no flow control.
package uart_cmd_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDATA = 4'h1;
  localparam logic [3:0] OP_ECHO  = 4'h2;
  localparam logic [3:0] OP_LADDR = 4'h4;
  localparam logic [3:0] OP_WRITE = 4'h6;
  localparam logic [3:0] OP_READ  = 4'h7;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_WAIT,
    TX
  } state_t;

endpackage

// File: rtl/uart_cmd_decoder_txser.sv
// Word-to-byte serializer, MSB byte first; valid rises the cycle after i_load.
// Each byte is held with valid high until i_tx_ready; o_done marks the last handshake.
module uart_cmd_txser #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_done
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  logic [DATA_W-1:0] r_word;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_vld;
  logic              w_hs;

  assign w_hs       = r_vld & i_tx_ready;
  assign o_done     = w_hs && (r_cnt == '0);
  assign o_tx_valid = r_vld;
  assign o_tx_data  = r_word[{r_cnt, 3'b000} +: 8];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= LAST;
      r_vld  <= 1'b1;
    end else if (w_hs) begin
      if (r_cnt == '0) r_vld <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Byte command decoder: nibble shift-loads data/addr, 1-cycle mem strobes, byte echo.
// Strobes/tx start the cycle after the opcode byte; bytes arriving while busy are dropped (o_overrun).
module uart_cmd_decoder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_overrun
);

  import uart_cmd_pkg::*;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ovr;
  logic              w_load, w_done, w_ld_data, w_ld_addr, w_cap;
  logic [3:0]        w_op, w_nib;
  logic [DATA_W-1:0] w_tx_word;

  assign w_op        = i_rx_data[3:0];
  assign w_nib       = i_rx_data[7:4];
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_data;
  assign o_overrun   = r_ovr;
  // Read data goes straight into the serializer in the same cycle it is captured.
  assign w_tx_word   = w_cap ? i_mem_rdata : r_data;

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_ld_data = 1'b0;
    w_ld_addr = 1'b0;
    w_cap     = 1'b0;
    o_mem_we  = 1'b0;
    o_mem_re  = 1'b0;
    o_busy    = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (i_rx_valid) begin
          case (w_op)
            OP_NOP:   ;
            OP_LDATA: w_ld_data = 1'b1;
            OP_ECHO:  begin w_next = TX; w_load = 1'b1; end
            OP_LADDR: w_ld_addr = 1'b1;
            OP_WRITE: w_next = WRITE;
            OP_READ:  w_next = RD_REQ;
            default:  ;
          endcase
        end
      end
      WRITE: begin
        o_mem_we = 1'b1;
        w_next   = IDLE;
      end
      RD_REQ: begin
        o_mem_re = 1'b1;
        w_next   = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_mem_rvalid) begin
          w_cap  = 1'b1;
          w_load = 1'b1;
          w_next = TX;
        end
      end
      TX:      if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_addr  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ovr   <= i_rx_valid && (r_state != IDLE);
      if (w_ld_data)  r_data <= {r_data[DATA_W-5:0], w_nib};
      else if (w_cap) r_data <= i_mem_rdata;
      if (w_ld_addr)  r_addr <= {r_addr[ADDR_W-5:0], w_nib};
    end
  end

  uart_cmd_txser #(.DATA_W(DATA_W)) u_txser (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_load     (w_load),
    .i_word     (w_tx_word),
    .i_tx_ready (i_tx_ready),
    .o_tx_valid (o_tx_valid),
    .o_tx_data  (o_tx_data),
    .o_done     (w_done)
  );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: vector table for loads/ignored opcodes,
// hand sequences for echo stalls, overrun, write/read round trip and mid-burst reset.
module tb_uart_cmd_decoder;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we, o_mem_re;
  logic [31:0] i_mem_rdata = 32'h0;
  logic        i_mem_rvalid = 1'b0;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready = 1'b0;
  logic        o_busy, o_overrun;

  always #5 i_clk = ~i_clk;

  uart_cmd_decoder #(.DATA_W(32), .ADDR_W(10)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
    .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  int total = 0;
  int bad = 0;
  int we_cnt = 0, re_cnt = 0, ovr_cnt = 0;
  logic [9:0]  we_addr = '0, re_addr = '0;
  logic [31:0] we_data = '0;
  logic [31:0] mem [int];
  logic [7:0]  txq [$];
  logic        prev_vld = 1'b0, prev_hs = 1'b0;
  logic [7:0]  prev_dat = 8'h00;

  typedef struct {
    logic [7:0]  rx;
    logic [31:0] data;
    logic [9:0]  addr;
  } vec_t;
  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  // Negedge monitor: handshakes, strobes and tx hold-stability.
  always @(negedge i_clk) begin
    if (i_nrst) begin
      if (prev_vld && !prev_hs && o_tx_valid) chk("tx_stable", {24'h0, o_tx_data}, {24'h0, prev_dat});
      if (o_tx_valid && i_tx_ready) txq.push_back(o_tx_data);
      if (o_mem_we) begin
        we_cnt++;
        we_addr = o_mem_addr;
        we_data = o_mem_wdata;
        mem[int'(o_mem_addr)] = o_mem_wdata;
      end
      if (o_mem_re) begin
        re_cnt++;
        re_addr = o_mem_addr;
      end
      if (o_overrun) ovr_cnt++;
    end
    prev_vld = o_tx_valid && i_nrst;
    prev_hs  = i_tx_ready;
    prev_dat = o_tx_data;
  end

  task automatic collect(input logic [31:0] want);
    logic [31:0] e;
    for (int n = 0; n < 200 && txq.size() < 4; n++) begin
      i_tx_ready = ~i_tx_ready;
      tick();
    end
    i_tx_ready = 1'b0;
    tick();
    chk("tx_count", txq.size(), 4);
    for (int k = 0; k < 4 && k < txq.size(); k++) begin
      e = want >> (8 * (3 - k));
      chk("tx_byte", {24'h0, txq[k]}, {24'h0, e[7:0]});
    end
    chk("tx_valid_end", o_tx_valid, 0);
    chk("busy_end", o_busy, 0);
  endtask

  task automatic run_echo(input logic [31:0] want, input int stall, input bit inject);
    txq.delete();
    i_tx_ready = 1'b0;
    send_byte(8'h02);
    chk("echo_lat", o_tx_valid, 1);
    chk("echo_first", {24'h0, o_tx_data}, {24'h0, want[31:24]});
    for (int i = 0; i < stall; i++) begin
      if (inject && i == stall / 2) begin
        send_byte(8'h11);
        chk("ovr_pulse", o_overrun, 1);
        chk("ovr_data_kept", o_mem_wdata, want);
      end else begin
        tick();
      end
    end
    collect(want);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    int n0;
    n0 = we_cnt;
    send_byte(8'h06);
    chk("we_lat", o_mem_we, 1);
    chk("we_addr_now", {22'h0, o_mem_addr}, {22'h0, a});
    tick();
    chk("we_one_cycle", o_mem_we, 0);
    tick();
    chk("we_count", we_cnt - n0, 1);
    chk("we_addr", {22'h0, we_addr}, {22'h0, a});
    chk("we_data", we_data, d);
  endtask

  initial begin
    vt[0]  = '{8'h11, 32'h00000001, 10'h000};
    vt[1]  = '{8'h21, 32'h00000012, 10'h000};
    vt[2]  = '{8'h31, 32'h00000123, 10'h000};
    vt[3]  = '{8'h41, 32'h00001234, 10'h000};
    vt[4]  = '{8'h51, 32'h00012345, 10'h000};
    vt[5]  = '{8'h61, 32'h00123456, 10'h000};
    vt[6]  = '{8'h71, 32'h01234567, 10'h000};
    vt[7]  = '{8'h81, 32'h12345678, 10'h000};
    vt[8]  = '{8'h03, 32'h12345678, 10'h000};
    vt[9]  = '{8'h05, 32'h12345678, 10'h000};
    vt[10] = '{8'h0F, 32'h12345678, 10'h000};
    vt[11] = '{8'h00, 32'h12345678, 10'h000};
    vt[12] = '{8'h54, 32'h12345678, 10'h005};
    vt[13] = '{8'hA4, 32'h12345678, 10'h05A};
    vt[14] = '{8'hF4, 32'h12345678, 10'h1AF};
    vt[15] = '{8'h34, 32'h12345678, 10'h2F3};

    repeat (3) tick();
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_data", {24'h0, o_tx_data}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_re", o_mem_re, 0);
    chk("rst_ovr", o_overrun, 0);
    chk("rst_addr", {22'h0, o_mem_addr}, 0);
    chk("rst_data", o_mem_wdata, 0);
    i_nrst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      send_byte(vt[i].rx);
      tick();
      chk("vec_data", o_mem_wdata, vt[i].data);
      chk("vec_addr", {22'h0, o_mem_addr}, {22'h0, vt[i].addr});
      chk("vec_busy", o_busy, 0);
    end
    chk("vec_no_we", we_cnt, 0);
    chk("vec_no_re", re_cnt, 0);
    chk("vec_no_ovr", ovr_cnt, 0);
    chk("vec_no_tx", txq.size(), 0);

    run_echo(32'h12345678, 2, 1'b0);
    run_echo(32'h12345678, 20, 1'b1);
    chk("ovr_once", ovr_cnt, 1);
    chk("ovr_data_after", o_mem_wdata, 32'h12345678);

    repeat (7) send_byte(8'h01);
    send_byte(8'hA1);
    repeat (5) send_byte(8'h04);
    repeat (3) send_byte(8'hF4);
    tick();
    chk("ld_data_a", o_mem_wdata, 32'h0000000A);
    chk("ld_addr_3ff", {22'h0, o_mem_addr}, 32'h3FF);
    do_write(10'h3FF, 32'h0000000A);
    repeat (7) send_byte(8'h01);
    send_byte(8'hB1);
    send_byte(8'hF4);
    send_byte(8'hE4);
    do_write(10'h3FE, 32'h0000000B);

    repeat (3) send_byte(8'hF4);
    i_mem_rdata  = 32'hDEADBEEF;
    i_mem_rvalid = 1'b1;
    tick();
    i_mem_rvalid = 1'b0;
    tick();
    chk("rvalid_idle_ignored", o_mem_wdata, 32'h0000000B);
    chk("rvalid_idle_busy", o_busy, 0);
    txq.delete();
    send_byte(8'h07);
    chk("re_lat", o_mem_re, 1);
    chk("re_addr", {22'h0, o_mem_addr}, 32'h3FF);
    tick();
    chk("re_one_cycle", o_mem_re, 0);
    chk("rd_wait_busy", o_busy, 1);
    tick();
    i_mem_rdata  = mem.exists(int'(re_addr)) ? mem[int'(re_addr)] : 32'h0;
    i_mem_rvalid = 1'b1;
    tick();
    i_mem_rvalid = 1'b0;
    chk("rd_tx_valid", o_tx_valid, 1);
    chk("rd_data_kept", o_mem_wdata, 32'h0000000A);
    chk("re_count", re_cnt, 1);
    collect(32'h0000000A);
    run_echo(32'h0000000A, 3, 1'b0);

    txq.delete();
    i_tx_ready = 1'b1;
    send_byte(8'h02);
    for (int n = 0; n < 50 && txq.size() < 2; n++) tick();
    i_nrst = 1'b0;
    #1;
    chk("mid_rst_tx_valid", o_tx_valid, 0);
    chk("mid_rst_data", o_mem_wdata, 0);
    chk("mid_rst_addr", {22'h0, o_mem_addr}, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_bytes", txq.size(), 2);
    i_tx_ready = 1'b0;
    tick();
    i_nrst = 1'b1;
    tick();
    run_echo(32'h00000000, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
